lane_array_driver: RTL and testbench

Parametrised bank of NUM_CH channels, each driving NUM_LANES output lanes of WIDTH bits; successor to the fixed four-output, zero-driven module used in instance arrays.
Lanes are written through a valid/ready port with a per-lane mask. Each write is either a hold write (value stays) or a timed pulse (value returns to 0 after PULSE_LEN cycles).
It sits where arrays of simple output drivers were instantiated, replacing the array with one registered block.

---
 rtl/lane_array_driver_if.sv | 37 +++
 rtl/lane_array_driver.sv | 111 +++++++++++
 tb/tb_lane_array_driver.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lane_array_driver_if.sv
// Write port for lane_array_driver: a valid/ready channel carrying a lane write.
//   wr_valid     master -> slave  write request
//   wr_ready     slave  -> master write can be accepted this cycle
//   wr_ch        master -> slave  target channel
//   wr_lane_mask master -> slave  bit i set = lane i is written
//   wr_data      master -> slave  lane i value at [i*WIDTH +: WIDTH]
//   wr_mode      master -> slave  0 = hold, 1 = pulse
interface lane_array_driver_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned CHW       = 2
);
    logic                       wr_valid;
    logic                       wr_ready;
    logic [CHW-1:0]             wr_ch;
    logic [NUM_LANES-1:0]       wr_lane_mask;
    logic [NUM_LANES*WIDTH-1:0] wr_data;
    logic                       wr_mode;

    modport master (
        output wr_valid,
        output wr_ch,
        output wr_lane_mask,
        output wr_data,
        output wr_mode,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_ch,
        input  wr_lane_mask,
        input  wr_data,
        input  wr_mode,
        output wr_ready
    );
endinterface

// File: rtl/lane_array_driver.sv
// Bank of NUM_CH channels, each driving NUM_LANES registered output lanes of WIDTH bits.
// Lanes are written through a valid/ready port with a per-lane mask; a write either holds
// its value or pulses it for PULSE_LEN cycles before the pulsed lanes return to 0.
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   wr       write port (slave side of lane_array_driver_if)
//   clr_all  synchronous clear of all lanes and pulses, overrides any write
//   lane_out channel c, lane i at [(c*NUM_LANES+i)*WIDTH +: WIDTH]
//   busy     per-channel pulse in progress; writes to a busy channel stall
module lane_array_driver #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned CHW       = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    lane_array_driver_if.slave                wr,
    input  logic                              clr_all,
    output logic [NUM_CH*NUM_LANES*WIDTH-1:0] lane_out,
    output logic [NUM_CH-1:0]                 busy
);

    localparam int unsigned LW   = NUM_LANES * WIDTH;
    localparam int unsigned CntW = $clog2(PULSE_LEN + 1);

    logic [NUM_CH-1:0][LW-1:0]        lane_q, lane_d;
    logic [NUM_CH-1:0][NUM_LANES-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0][CntW-1:0]      cnt_q, cnt_d;
    logic [NUM_CH-1:0]                busy_q, busy_d;

    logic [NUM_CH-1:0] ch_sel;
    logic              sel_busy;
    logic              accept;
    logic [LW-1:0]     wr_bits;

    // Widen a per-lane mask to a per-bit mask.
    function automatic logic [LW-1:0] expand(input logic [NUM_LANES-1:0] m);
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            r[i*WIDTH +: WIDTH] = {WIDTH{m[i]}};
        end
        return r;
    endfunction

    // One-hot channel decode; an out-of-range wr_ch selects nothing, so it is
    // never stalled and its accepted write falls on the floor.
    always_comb begin
        ch_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sel[c] = (wr.wr_ch == CHW'(c));
        end
    end

    assign sel_busy    = |(ch_sel & busy_q);
    assign wr.wr_ready = !rst && !clr_all && !sel_busy;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign wr_bits     = expand(wr.wr_lane_mask);

    always_comb begin
        lane_d = lane_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cnt_q[c] != '0) begin
                cnt_d[c] = cnt_q[c] - CntW'(1);
                // Last pulse cycle: only the lanes this pulse wrote fall back to 0.
                if (cnt_q[c] == CntW'(1)) begin
                    lane_d[c] = lane_q[c] & ~expand(mask_q[c]);
                    mask_d[c] = '0;
                end
            end
            // A selected channel is never busy when accepted, so the write cannot
            // collide with the pulse-end update above.
            if (accept && ch_sel[c]) begin
                lane_d[c] = (lane_d[c] & ~wr_bits) | (wr.wr_data & wr_bits);
                if (wr.wr_mode && (wr.wr_lane_mask != '0)) begin
                    mask_d[c] = wr.wr_lane_mask;
                    cnt_d[c]  = CntW'(PULSE_LEN);
                end
            end
            if (clr_all) begin
                lane_d[c] = '0;
                mask_d[c] = '0;
                cnt_d[c]  = '0;
            end
            busy_d[c] = (cnt_d[c] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            mask_q <= '0;
            cnt_q  <= '0;
            busy_q <= '0;
        end else begin
            lane_q <= lane_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign lane_out = lane_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_lane_array_driver.sv
// Directed bench for lane_array_driver: a 4-channel instance driven from a vector
// table, plus a 3-channel instance for the out-of-range channel corner.
module tb_lane_array_driver;

    logic clk = 1'b0;
    logic rst;
    logic clr_all;
    logic clr3;
    logic [15:0] lane_out;
    logic [3:0]  busy;
    logic [11:0] lane_out3;
    logic [2:0]  busy3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lane_array_driver_if #(.NUM_LANES(4), .WIDTH(1), .CHW(2)) wr_if ();
    lane_array_driver_if #(.NUM_LANES(4), .WIDTH(1), .CHW(2)) wr3_if ();

    lane_array_driver #(
        .NUM_CH(4), .NUM_LANES(4), .WIDTH(1), .PULSE_LEN(4), .CHW(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr_if.slave),
        .clr_all  (clr_all),
        .lane_out (lane_out),
        .busy     (busy)
    );

    lane_array_driver #(
        .NUM_CH(3), .NUM_LANES(4), .WIDTH(1), .PULSE_LEN(4), .CHW(2)
    ) dut3 (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr3_if.slave),
        .clr_all  (clr3),
        .lane_out (lane_out3),
        .busy     (busy3)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  ch;
        logic [3:0]  mask;
        logic [3:0]  data;
        logic        mode;
        logic        clr;
        logic        exp_ready;
        logic [15:0] exp_lane;
        logic [3:0]  exp_busy;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [3:0] m,
                         input logic [3:0] d, input logic md, input logic c);
        wr_if.wr_valid     = v;
        wr_if.wr_ch        = ch;
        wr_if.wr_lane_mask = m;
        wr_if.wr_data      = d;
        wr_if.wr_mode      = md;
        clr_all            = c;
    endtask

    task automatic drive3(input logic v, input logic [1:0] ch, input logic [3:0] m,
                          input logic [3:0] d, input logic md);
        wr3_if.wr_valid     = v;
        wr3_if.wr_ch        = ch;
        wr3_if.wr_lane_mask = m;
        wr3_if.wr_data      = d;
        wr3_if.wr_mode      = md;
    endtask

    initial begin
        //             vld ch  mask     data     md   clr  rdy  lane      busy
        vecs[0]  = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000};
        vecs[1]  = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000};
        vecs[2]  = '{1'b1, 2'd2, 4'b0101, 4'b1111, 1'b0, 1'b0, 1'b1, 16'h0500, 4'b0000};
        vecs[3]  = '{1'b1, 2'd1, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1, 16'h0580, 4'b0000};
        vecs[4]  = '{1'b1, 2'd1, 4'b0011, 4'b1111, 1'b1, 1'b0, 1'b1, 16'h05B0, 4'b0010};
        vecs[5]  = '{1'b1, 2'd3, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 16'h15B0, 4'b0010};
        vecs[6]  = '{1'b1, 2'd1, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 16'h15B0, 4'b0010};
        vecs[7]  = '{1'b1, 2'd1, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 16'h15B0, 4'b0010};
        vecs[8]  = '{1'b1, 2'd1, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 16'h1580, 4'b0000};
        vecs[9]  = '{1'b1, 2'd1, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 16'h15C0, 4'b0000};
        vecs[10] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h15C0, 4'b0000};
        vecs[11] = '{1'b1, 2'd0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 16'h15C0, 4'b0000};
        vecs[12] = '{1'b1, 2'd0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 16'h15C0, 4'b0000};
        vecs[13] = '{1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 16'h15CF, 4'b0001};
        vecs[14] = '{1'b1, 2'd3, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000};
        vecs[15] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000};
        vecs[16] = '{1'b1, 2'd2, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 16'h0F00, 4'b0100};
        vecs[17] = '{1'b1, 2'd3, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 16'h1F00, 4'b1100};
        vecs[18] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h1F00, 4'b1100};
        vecs[19] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h1F00, 4'b1100};
        vecs[20] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h1000, 4'b1000};
        vecs[21] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000};

        // Reset
        rst  = 1'b1;
        clr3 = 1'b0;
        drive(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive3(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset lane_out", 32'(lane_out), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset ready", 32'(wr_if.wr_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("ready after reset", 32'(wr_if.wr_ready), 32'h1);

        // Vector table: ready sampled before the edge, state after it.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].valid, vecs[i].ch, vecs[i].mask, vecs[i].data, vecs[i].mode,
                  vecs[i].clr);
            #1;
            chk($sformatf("v%0d ready", i), 32'(wr_if.wr_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d lane_out", i), 32'(lane_out), 32'(vecs[i].exp_lane));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
        end

        // Reset asserted mid-pulse aborts it.
        drive(1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("pre-rst busy", 32'(busy), 32'h1);
        drive(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst ready", 32'(wr_if.wr_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst mid-pulse lane", 32'(lane_out), 32'h0);
        chk("rst mid-pulse busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        chk("post-rst lane", 32'(lane_out), 32'h0);
        chk("post-rst ready", 32'(wr_if.wr_ready), 32'h1);

        // Three-channel instance: out-of-range channel and empty pulse mask.
        drive3(1'b1, 2'd2, 4'b1111, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        chk("n3 hold ch2", 32'(lane_out3), 32'hF00);
        drive3(1'b1, 2'd3, 4'b1111, 4'b0000, 1'b0);
        #1;
        chk("n3 oor ready", 32'(wr3_if.wr_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("n3 oor hold lane", 32'(lane_out3), 32'hF00);
        drive3(1'b1, 2'd3, 4'b1111, 4'b0000, 1'b1);
        #1;
        chk("n3 oor pulse ready", 32'(wr3_if.wr_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("n3 oor pulse lane", 32'(lane_out3), 32'hF00);
        chk("n3 oor pulse busy", 32'(busy3), 32'h0);
        drive3(1'b1, 2'd0, 4'b0000, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        chk("n3 zero-mask pulse busy", 32'(busy3), 32'h0);
        chk("n3 zero-mask pulse lane", 32'(lane_out3), 32'hF00);
        drive3(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        chk("n3 idle busy", 32'(busy3), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
